// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: radix-2 shift-and-add unsigned multiplier, one multiplier bit per clock
// Ports: clk, reset (async, active high), start (sampled in IDLE), a_in/b_in (N-bit operands),
//        busy (high in CALC), done (one-cycle pulse), product (2N-bit, held until next completion)
// Option: define SHIFT_ADD_MULT_EARLY_EXIT_EN to finish as soon as no multiplier bits remain
module shift_add_multiplier #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N-1:0]     a_in,
  input  logic [N-1:0]     b_in,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   product
);
  localparam int CW = $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [2*N-1:0] mcand, acc, acc_nx;
  logic [N-1:0] mplier;
  logic [CW-1:0] cnt;
  logic last;
  always_comb begin
    acc_nx = mplier[0] ? acc + mcand : acc;
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
    last = cnt == CW'(N - 1) || mplier[N-1:1] == '0;
`else
    last = cnt == CW'(N - 1);
`endif
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mcand  <= {{N{1'b0}}, a_in};
          mplier <= b_in;
          acc    <= '0;
          cnt    <= '0;
          busy   <= 1'b1;
          state  <= CALC;
        end
        CALC: begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last) begin
            product <= acc_nx;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
